// File: rtl/gbdt_pkg.sv
`default_nettype none
// ============================================================================
// gbdt_pkg : node word field map, walker FSM states and shared widths.
// Rev 1.0
// ============================================================================
package gbdt_pkg;

  localparam int LEAF_BIT = 0;
  localparam int FEAT_LSB = 1;
  localparam int FEAT_MSB = 7;
  localparam int ROFF_LSB = 8;
  localparam int ROFF_MSB = 15;
  localparam int VAL_LSB  = 16;
  localparam int VAL_MSB  = 31;

  localparam int FEAT_AW  = 7;
  localparam int ROFF_W   = ROFF_MSB - ROFF_LSB + 1;
  localparam int VAL_W    = VAL_MSB - VAL_LSB + 1;
  localparam int FEAT_W   = 16;

  typedef enum logic [2:0] {
    TW_IDLE      = 3'd0,
    TW_ROOT_REQ  = 3'd1,
    TW_ROOT_WAIT = 3'd2,
    TW_NODE_REQ  = 3'd3,
    TW_NODE_WAIT = 3'd4,
    TW_FEAT_WAIT = 3'd5,
    TW_LEAF      = 3'd6
  } tw_state_t;

endpackage
`default_nettype wire

// File: rtl/tree_walker_if.sv
`default_nettype none
// ============================================================================
// tree_walker_if : start/status, RAM read ports and leaves_acc drive bundle.
// Rev 1.0
// ============================================================================
interface tree_walker_if #(
  parameter int NODE_AW = 10,
  parameter int TREE_W  = 8
);
  logic               start;
  logic [TREE_W-1:0]  num_trees;
  logic               root_rd_en;
  logic [TREE_W-1:0]  root_idx;
  logic [NODE_AW-1:0] root_ptr;
  logic               node_rd_en;
  logic [NODE_AW-1:0] node_addr;
  logic [31:0]        node_data;
  logic               feat_rd_en;
  logic [6:0]         feat_addr;
  logic [15:0]        feat_data;
  logic               acc_start_new_round;
  logic               acc_enable;
  logic               acc_is_leaf;
  logic [15:0]        acc_leaf_val;
  logic               acc_finish;
  logic               busy;
  logic               err;

  modport master (
    input  start, num_trees, root_ptr, node_data, feat_data,
    output root_rd_en, root_idx, node_rd_en, node_addr, feat_rd_en, feat_addr,
           acc_start_new_round, acc_enable, acc_is_leaf, acc_leaf_val,
           acc_finish, busy, err
  );

  modport slave (
    output start, num_trees, root_ptr, node_data, feat_data,
    input  root_rd_en, root_idx, node_rd_en, node_addr, feat_rd_en, feat_addr,
           acc_start_new_round, acc_enable, acc_is_leaf, acc_leaf_val,
           acc_finish, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/node_cmp.sv
`default_nettype none
// ============================================================================
// node_cmp : unsigned feature/threshold compare and child-pointer select.
// Rev 1.0
// ============================================================================
module node_cmp
  import gbdt_pkg::*;
#(
  parameter int NODE_AW = 10
) (
  input  wire logic [VAL_W-1:0]   thr_i,
  input  wire logic [ROFF_W-1:0]  roff_i,
  input  wire logic [FEAT_W-1:0]  feat_i,
  input  wire logic [NODE_AW-1:0] ptr_i,
  output logic                    go_left_o,
  output logic [NODE_AW-1:0]      next_ptr_o
);

  // Equal values take the right branch; both sums wrap in the node space.
  assign go_left_o  = (feat_i < thr_i);
  assign next_ptr_o = go_left_o ? (ptr_i + NODE_AW'(1))
                                : (ptr_i + NODE_AW'(roff_i));

endmodule
`default_nettype wire

// File: rtl/tree_walker.sv
`default_nettype none
// ============================================================================
// tree_walker : walks trees 0..num_trees-1 and emits one leaf pulse per tree.
// Rev 1.0
// ============================================================================
module tree_walker
  import gbdt_pkg::*;
#(
  parameter int NODE_AW   = 10,
  parameter int TREE_W    = 8,
  parameter int MAX_DEPTH = 15
) (
  input  wire logic     gbdt_clk,
  input  wire logic     gbdt_rst_n,
  tree_walker_if.master bus
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  tw_state_t          state_q,     state_d;
  logic [TREE_W-1:0]  tree_idx_q,  tree_idx_d;
  logic [TREE_W-1:0]  num_trees_q, num_trees_d;
  logic [DEPTH_W-1:0] depth_q,     depth_d;
  logic [NODE_AW-1:0] node_ptr_q,  node_ptr_d;
  logic [VAL_W-1:0]   thr_q,       thr_d;
  logic [ROFF_W-1:0]  roff_q,      roff_d;
  logic [VAL_W-1:0]   leaf_val_q,  leaf_val_d;
  logic               err_q,       err_d;

  logic               go_left;
  logic [NODE_AW-1:0] next_ptr;
  logic               last_tree;
  logic               nd_leaf;
  logic [ROFF_W-1:0]  nd_roff;
  logic [VAL_W-1:0]   nd_val;

  assign nd_leaf   = bus.node_data[LEAF_BIT];
  assign nd_roff   = bus.node_data[ROFF_MSB:ROFF_LSB];
  assign nd_val    = bus.node_data[VAL_MSB:VAL_LSB];
  assign last_tree = (tree_idx_q == (num_trees_q - TREE_W'(1)));

  node_cmp #(.NODE_AW(NODE_AW)) u_cmp (
    .thr_i      (thr_q),
    .roff_i     (roff_q),
    .feat_i     (bus.feat_data),
    .ptr_i      (node_ptr_q),
    .go_left_o  (go_left),
    .next_ptr_o (next_ptr)
  );

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      state_q     <= TW_IDLE;
      tree_idx_q  <= '0;
      num_trees_q <= '0;
      depth_q     <= '0;
      node_ptr_q  <= '0;
      thr_q       <= '0;
      roff_q      <= '0;
      leaf_val_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tree_idx_q  <= tree_idx_d;
      num_trees_q <= num_trees_d;
      depth_q     <= depth_d;
      node_ptr_q  <= node_ptr_d;
      thr_q       <= thr_d;
      roff_q      <= roff_d;
      leaf_val_q  <= leaf_val_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tree_idx_d  = tree_idx_q;
    num_trees_d = num_trees_q;
    depth_d     = depth_q;
    node_ptr_d  = node_ptr_q;
    thr_d       = thr_q;
    roff_d      = roff_q;
    leaf_val_d  = leaf_val_q;
    err_d       = err_q;

    bus.root_rd_en          = 1'b0;
    bus.node_rd_en          = 1'b0;
    bus.feat_rd_en          = 1'b0;
    bus.feat_addr           = '0;
    bus.acc_start_new_round = 1'b0;
    bus.acc_enable          = 1'b0;
    bus.acc_is_leaf         = 1'b0;
    bus.acc_finish          = 1'b0;

    unique case (state_q)
      TW_IDLE: begin
        if (bus.start) begin
          if (bus.num_trees != '0) begin
            bus.acc_start_new_round = 1'b1;
            num_trees_d = bus.num_trees;
            tree_idx_d  = '0;
            depth_d     = '0;
            err_d       = 1'b0;
            state_d     = TW_ROOT_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      TW_ROOT_REQ: begin
        bus.root_rd_en = 1'b1;
        state_d        = TW_ROOT_WAIT;
      end
      TW_ROOT_WAIT: begin
        node_ptr_d = bus.root_ptr;
        depth_d    = '0;
        state_d    = TW_NODE_REQ;
      end
      TW_NODE_REQ: begin
        bus.node_rd_en = 1'b1;
        state_d        = TW_NODE_WAIT;
      end
      TW_NODE_WAIT: begin
        if (nd_leaf) begin
          leaf_val_d = nd_val;
          state_d    = TW_LEAF;
        end else if ((nd_roff == '0) || (depth_q == DEPTH_W'(MAX_DEPTH))) begin
          // Malformed tree or runaway depth: abort without touching leaves_acc.
          err_d   = 1'b1;
          state_d = TW_IDLE;
        end else begin
          bus.feat_rd_en = 1'b1;
          bus.feat_addr  = bus.node_data[FEAT_MSB:FEAT_LSB];
          thr_d          = nd_val;
          roff_d         = nd_roff;
          state_d        = TW_FEAT_WAIT;
        end
      end
      TW_FEAT_WAIT: begin
        node_ptr_d = next_ptr;
        depth_d    = depth_q + DEPTH_W'(1);
        state_d    = TW_NODE_REQ;
      end
      TW_LEAF: begin
        bus.acc_enable  = 1'b1;
        bus.acc_is_leaf = 1'b1;
        bus.acc_finish  = last_tree;
        if (last_tree) begin
          state_d = TW_IDLE;
        end else begin
          tree_idx_d = tree_idx_q + TREE_W'(1);
          state_d    = TW_ROOT_REQ;
        end
      end
      default: state_d = TW_IDLE;
    endcase
  end

  assign bus.root_idx     = tree_idx_q;
  assign bus.node_addr    = node_ptr_q;
  assign bus.acc_leaf_val = leaf_val_q;
  assign bus.busy         = (state_q != TW_IDLE);
  assign bus.err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_walker.sv
`default_nettype none
// ============================================================================
// tb_tree_walker : directed vectors against RAM models and a leaves_acc model.
// Rev 1.0
// ============================================================================
module tb_tree_walker;

  localparam int NODE_AW = 10;
  localparam int TREE_W  = 8;

  logic gbdt_clk;
  logic gbdt_rst_n;

  tree_walker_if #(.NODE_AW(NODE_AW), .TREE_W(TREE_W)) bus ();

  tree_walker #(.NODE_AW(NODE_AW), .TREE_W(TREE_W), .MAX_DEPTH(15)) u_dut (
    .gbdt_clk   (gbdt_clk),
    .gbdt_rst_n (gbdt_rst_n),
    .bus        (bus.master)
  );

  initial gbdt_clk = 1'b0;
  always #5 gbdt_clk = ~gbdt_clk;

  logic [NODE_AW-1:0] root_mem [0:255];
  logic [31:0]        node_mem [0:1023];
  logic [15:0]        feat_mem [0:127];

  always @(posedge gbdt_clk) begin
    if (bus.root_rd_en) bus.root_ptr  <= root_mem[bus.root_idx];
    if (bus.node_rd_en) bus.node_data <= node_mem[bus.node_addr];
    if (bus.feat_rd_en) bus.feat_data <= feat_mem[bus.feat_addr];
  end

  // leaves_acc reference behaviour plus pulse bookkeeping, sampled mid-cycle
  int          ncyc = 0;
  int          snr_cnt = 0;
  int          snr_cyc = 0;
  int          en_cnt = 0;
  int          fin_cnt = 0;
  int          fin_at = 0;
  int          en_cyc [0:3];
  logic [31:0] acc_sum = 0;
  logic        acc_done = 1'b0;

  always @(negedge gbdt_clk) begin
    ncyc <= ncyc + 1;
    if (bus.acc_start_new_round) begin
      snr_cnt  <= snr_cnt + 1;
      snr_cyc  <= ncyc;
      en_cnt   <= 0;
      fin_cnt  <= 0;
      fin_at   <= 0;
      acc_sum  <= 0;
      acc_done <= 1'b0;
    end else begin
      if (bus.acc_enable) begin
        if (en_cnt < 4) en_cyc[en_cnt] <= ncyc;
        en_cnt  <= en_cnt + 1;
        acc_sum <= acc_sum + 32'(bus.acc_leaf_val);
        if (bus.acc_finish) begin
          fin_at   <= en_cnt + 1;
          acc_done <= 1'b1;
        end
      end
      if (bus.acc_finish) fin_cnt <= fin_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [TREE_W-1:0] n);
    @(posedge gbdt_clk); #1;
    bus.start     = 1'b1;
    bus.num_trees = n;
    @(posedge gbdt_clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge gbdt_clk);
    while (bus.busy && k < 200) begin
      @(negedge gbdt_clk);
      k++;
    end
    if (bus.busy) check({tag, "_timeout"}, 1, 0);
  endtask

  function automatic logic [31:0] leaf(input logic [15:0] v);
    return {v, 8'd0, 7'd0, 1'b1};
  endfunction

  function automatic logic [31:0] inode(input logic [15:0] thr, input logic [7:0] roff,
                                        input logic [6:0] f);
    return {thr, roff, f, 1'b0};
  endfunction

  int snr_before;

  initial begin
    bus.start     = 1'b0;
    bus.num_trees = '0;
    for (int i = 0; i < 256;  i++) root_mem[i] = '0;
    for (int i = 0; i < 1024; i++) node_mem[i] = '0;
    for (int i = 0; i < 128;  i++) feat_mem[i] = '0;

    // stump at 0, three leaf-only roots at 10..12, left-going chain at 100..115
    node_mem[0]  = inode(16'd100, 8'd2, 7'd3);
    node_mem[1]  = leaf(16'd5);
    node_mem[2]  = leaf(16'd9);
    node_mem[10] = leaf(16'd1);
    node_mem[11] = leaf(16'd2);
    node_mem[12] = leaf(16'd3);
    for (int i = 100; i < 116; i++) node_mem[i] = inode(16'hFFFF, 8'd1, 7'd4);
    node_mem[116] = leaf(16'd77);
    feat_mem[3] = 16'd50;
    feat_mem[4] = 16'd0;

    gbdt_rst_n = 1'b0;
    repeat (3) @(posedge gbdt_clk);
    @(negedge gbdt_clk);
    check("reset_ctrl", {29'd0, bus.busy, bus.err, bus.acc_start_new_round}, 0);
    check("reset_strobes", {27'd0, bus.root_rd_en, bus.node_rd_en, bus.feat_rd_en,
                            bus.acc_enable, bus.acc_finish}, 0);
    check("reset_leafval", bus.acc_leaf_val, 0);
    check("reset_addrs", {7'd0, bus.root_idx, bus.node_addr, bus.feat_addr}, 0);
    #1 gbdt_rst_n = 1'b1;

    // single stump, left branch
    root_mem[0] = 10'd0;
    do_start(8'd1);
    wait_idle("stump_l");
    check("stump_l_en", en_cnt, 1);
    check("stump_l_val", acc_sum, 5);
    check("stump_l_done", acc_done, 1);
    check("stump_l_lat", en_cyc[0] - snr_cyc, 8);
    check("stump_l_fin", fin_at, 1);

    // equal feature goes right
    feat_mem[3] = 16'd100;
    do_start(8'd1);
    wait_idle("stump_eq");
    check("stump_eq_val", acc_sum, 9);
    check("stump_eq_leafout", bus.acc_leaf_val, 9);

    // three leaf-only trees
    root_mem[0] = 10'd10;
    root_mem[1] = 10'd11;
    root_mem[2] = 10'd12;
    do_start(8'd3);
    wait_idle("three");
    check("three_en", en_cnt, 3);
    check("three_sum", acc_sum, 6);
    check("three_fin_cnt", fin_cnt, 1);
    check("three_fin_at", fin_at, 3);
    check("three_lat0", en_cyc[0] - snr_cyc, 5);
    check("three_gap1", en_cyc[1] - en_cyc[0], 5);
    check("three_gap2", en_cyc[2] - en_cyc[1], 5);

    // depth overflow on a 16-deep chain
    root_mem[0] = 10'd100;
    do_start(8'd1);
    wait_idle("depth");
    check("depth_err", bus.err, 1);
    check("depth_no_en", en_cnt, 0);
    check("depth_not_done", acc_done, 0);
    root_mem[0] = 10'd0;
    snr_before = snr_cnt;
    do_start(8'd1);
    check("recover_err_clr", bus.err, 0);
    check("recover_snr", snr_cnt - snr_before, 1);
    wait_idle("recover");
    check("recover_val", acc_sum, 9);

    // num_trees == 0 is refused
    snr_before = snr_cnt;
    do_start(8'd0);
    @(negedge gbdt_clk);
    check("zero_err", bus.err, 1);
    check("zero_busy", bus.busy, 0);
    check("zero_no_snr", snr_cnt - snr_before, 0);

    // start (and num_trees change) while busy is ignored
    snr_before = snr_cnt;
    do_start(8'd1);
    @(posedge gbdt_clk); #1;
    bus.start     = 1'b1;
    bus.num_trees = 8'd3;
    @(posedge gbdt_clk); #1;
    bus.start     = 1'b0;
    wait_idle("busy_start");
    check("busy_snr", snr_cnt - snr_before, 1);
    check("busy_en", en_cnt, 1);
    check("busy_val", acc_sum, 9);

    // reset while in FEAT_WAIT
    bus.num_trees = 8'd1;
    do_start(8'd1);
    begin
      int k;
      k = 0;
      @(negedge gbdt_clk);
      while (!bus.feat_rd_en && k < 20) begin
        @(negedge gbdt_clk);
        k++;
      end
      check("rst_saw_feat", bus.feat_rd_en, 1);
    end
    @(posedge gbdt_clk); #1;
    gbdt_rst_n = 1'b0;
    @(negedge gbdt_clk);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_outs", {24'd0, bus.acc_enable, bus.acc_finish, bus.acc_is_leaf,
                           bus.root_rd_en, bus.node_rd_en, bus.feat_rd_en, bus.err,
                           bus.acc_start_new_round}, 0);
    check("rst_mid_leafval", bus.acc_leaf_val, 0);
    check("rst_mid_no_en", en_cnt, 0);
    #1 gbdt_rst_n = 1'b1;
    do_start(8'd1);
    wait_idle("post_rst");
    check("post_rst_val", acc_sum, 9);
    check("post_rst_done", acc_done, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tree_walker.md
Name: tree_walker

Overview:
- Upstream traversal engine for leaves_acc; one inference round walks trees 0..num_trees-1 in order.
- Per tree: fetch root pointer, then descend node by node, comparing a 16-bit feature against each node's threshold, until a leaf is reached.
- Each leaf is presented to the accumulator as a one-cycle enable pulse; the last tree's leaf carries the finish flag.
- Reads node, root-table and feature RAMs through synchronous read ports with 1-cycle latency.

Parameters:
- NODE_AW, 10, node RAM address width.
- TREE_W, 8, tree index / num_trees width.
- MAX_DEPTH, 15, maximum internal nodes visited per tree before the error abort.

Ports:
- gbdt_clk  in  1  clock
- gbdt_rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a round; sampled in IDLE only
- num_trees  in  TREE_W  trees per round; 0 is illegal
- root_rd_en  out  1  root-table read strobe
- root_idx  out  TREE_W  root-table address (= tree_idx)
- root_ptr  in  NODE_AW  root node address, valid 1 cycle after root_rd_en
- node_rd_en  out  1  node RAM read strobe
- node_addr  out  NODE_AW  node RAM address
- node_data  in  32  node word, valid 1 cycle after node_rd_en
- feat_rd_en  out  1  feature RAM read strobe
- feat_addr  out  7  feature index
- feat_data  in  16  feature value, valid 1 cycle after feat_rd_en
- acc_start_new_round  out  1  one-cycle pulse to leaves_acc.start_new_round
- acc_enable  out  1  leaf-valid pulse to leaves_acc.enable
- acc_is_leaf  out  1  to leaves_acc.is_leaf
- acc_leaf_val  out  16  to leaves_acc.leaf_val
- acc_finish  out  1  to leaves_acc.finish_condition
- busy  out  1  high in every state except IDLE
- err  out  1  sticky error; cleared by an accepted start

Behaviour:
- Node word layout:
  - [0] is_leaf.
  - [7:1] feature index.
  - [15:8] right_offset: right child = ptr + right_offset, wrapping mod 2^NODE_AW; left child = ptr + 1 (pre-order layout).
  - [31:16] threshold for an internal node, leaf_val for a leaf.
- Reset state: all outputs 0, FSM in IDLE, tree_idx=0, depth=0, node_ptr=0.
- Reset asserted mid-round returns the block to IDLE immediately. No acc pulse is emitted.
- FSM states: IDLE, ROOT_REQ, ROOT_WAIT, NODE_REQ, NODE_WAIT, FEAT_WAIT, LEAF.
- IDLE:
  - start with num_trees!=0: acc_start_new_round=1 for this cycle; clear tree_idx, depth and err; go to ROOT_REQ.
  - start with num_trees==0: set err, stay in IDLE, no start_new_round pulse.
- ROOT_REQ: root_rd_en=1, root_idx=tree_idx -> ROOT_WAIT.
- ROOT_WAIT: node_ptr<=root_ptr, depth<=0 -> NODE_REQ.
- NODE_REQ: node_rd_en=1, node_addr=node_ptr -> NODE_WAIT.
- NODE_WAIT: latch node_data.
  - Leaf -> LEAF.
  - Internal with right_offset==0 or depth==MAX_DEPTH: set err -> IDLE (abort).
  - Otherwise: in the same cycle, feat_rd_en=1 and feat_addr=node_data[7:1] (combinational from node_data); go to FEAT_WAIT.
- FEAT_WAIT: unsigned compare.
  - feat_data < threshold: node_ptr<=node_ptr+1.
  - Otherwise (equal goes right): node_ptr<=node_ptr+right_offset.
  - depth++ -> NODE_REQ.
- LEAF:
  - acc_enable=1, acc_is_leaf=1, acc_leaf_val=latched leaf_val, acc_finish=(tree_idx==num_trees-1), all for exactly one cycle.
  - Last tree -> IDLE; otherwise tree_idx++ -> ROOT_REQ.
- acc_enable, acc_finish and acc_is_leaf are 0 outside LEAF. acc_leaf_val holds its last value.
- Latency per tree: 5 + 3*(internal nodes on path) cycles from ROOT_REQ to the LEAF cycle inclusive.
- num_trees is sampled at start and held internally; later changes mid-round are ignored.
- start while busy is ignored.
- An error abort leaves leaves_acc not done. Recovery is a new start, which pulses start_new_round.

Decomposition:
- Shared package gbdt_pkg:
  - Node field positions/widths: LEAF_BIT, FEAT_LSB/MSB, ROFF_LSB/MSB, VAL_LSB/MSB.
  - FSM state enum tw_state_t.
  - Feature address width constant (7).
- Optional sub-module node_cmp: combinational field decode, unsigned compare and next-pointer mux. Everything else stays in tree_walker.

Test Plan:
- Single stump: num_trees=1, root_ptr=0, node0={thr=100,f=3,roff=2,internal}, node1=leaf 5, node2=leaf 9, feat[3]=50. Expect acc_enable+acc_finish with leaf_val=5 exactly 8 cycles after start; paired leaves_acc result=5, done=1.
- Equal-threshold path: same image with feat[3]=100. Expect right branch, leaf_val=9.
- Three trees, leaf-only roots with values 1, 2, 3: expect three enable pulses 5 cycles apart, finish only on the third; leaves_acc result=6.
- Depth overflow: chain of 16 internal nodes, all going left. Expect err=1, return to IDLE, no acc_enable; next start clears err and pulses acc_start_new_round.
- Illegal starts: num_trees=0 -> err=1, no start_new_round pulse. Start while busy -> ignored, round result unchanged.
- Reset mid-round: assert gbdt_rst_n low during FEAT_WAIT. Expect all outputs 0 and IDLE; a following start runs a clean round.
